// File: rtl/hub75_bcm_scheduler_if.sv
// Shift/latch handshake between the BCM scheduler (master) and the HUB75 color transmitter (slave).
interface hub75_bcm_scheduler_if #(
    parameter int addr_wd_p = 12,
    parameter int bit_wd_p  = 3
);
    logic                 o_tx_start;
    logic [addr_wd_p-1:0] o_init_addr;
    logic [bit_wd_p-1:0]  o_pix_bit;
    logic                 i_tx_ready;

    modport master (
        output o_tx_start,
        output o_init_addr,
        output o_pix_bit,
        input  i_tx_ready
    );

    modport slave (
        input  o_tx_start,
        input  o_init_addr,
        input  o_pix_bit,
        output i_tx_ready
    );
endinterface

// File: rtl/hub75_bcm_scheduler.sv
// Binary-code-modulation frame scheduler: walks rows x bit-planes, kicks the transmitter for each
// pair, then drives the panel row address and a blanked, binary-weighted output-enable window.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | stopped, waiting for enable with an idle transmitter
// WAIT_ACK  | start pulse issued, waiting for transmitter to go busy
// WAIT_DONE | transmitter shifting/latching, waiting for ready
// BLANK     | row address updated, OE held off for dead_p cycles
// DISPLAY   | OE active for oe_base << bit cycles
// NEXT      | advance plane/row once, then start next transaction or stop
module hub75_bcm_scheduler #(
    parameter int hpixel_p     = 64,
    parameter int vpixel_p     = 64,
    parameter int bpp_p        = 8,
    parameter int segments_p   = 2,
    parameter int oe_base_wd_p = 16,
    parameter int dead_p       = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_enable,
    input  logic [oe_base_wd_p-1:0]                   i_oe_base,
    hub75_bcm_scheduler_if.master                     tx,
    output logic [$clog2(vpixel_p/segments_p)-1:0]    o_row_addr,
    output logic                                      o_oe_n,
    output logic                                      o_busy,
    output logic                                      o_frame_done
);
    localparam int rows_p   = vpixel_p / segments_p;
    localparam int row_wd   = $clog2(rows_p);
    localparam int bit_wd   = $clog2(bpp_p);
    localparam int addr_wd  = $clog2(hpixel_p * vpixel_p);
    localparam int on_wd    = oe_base_wd_p + bpp_p;
    localparam int dead_wd  = (dead_p > 1) ? $clog2(dead_p) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE,
        BLANK,
        DISPLAY,
        NEXT
    } state_t;

    state_t                  state;
    logic [row_wd-1:0]       row_q;
    logic [bit_wd-1:0]       bit_q;
    logic [oe_base_wd_p-1:0] oe_base_q;
    logic [dead_wd-1:0]      dead_cnt;
    logic [on_wd-1:0]        oe_cnt;
    logic                    adv_q;

    logic [on_wd-1:0]        on_time;
    logic                    row_last;
    logic                    bit_last;
    logic                    wrap;
    logic [row_wd-1:0]       row_nxt;
    logic [bit_wd-1:0]       bit_nxt;
    logic [row_wd-1:0]       sel_row;
    logic [bit_wd-1:0]       sel_bit;

    // Widened before the shift so the MSB plane's weight is never truncated.
    assign on_time  = on_wd'(oe_base_q) << bit_q;
    assign row_last = (row_q == row_wd'(rows_p - 1));
    assign bit_last = (bit_q == bit_wd'(bpp_p - 1));
    assign wrap     = row_last && bit_last;
    assign row_nxt  = bit_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
    assign bit_nxt  = bit_last ? '0 : bit_q + 1'b1;

    // While parked in NEXT the counters have already advanced; use them as-is.
    assign sel_row  = adv_q ? row_q : row_nxt;
    assign sel_bit  = adv_q ? bit_q : bit_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            row_q          <= '0;
            bit_q          <= '0;
            oe_base_q      <= '0;
            dead_cnt       <= '0;
            oe_cnt         <= '0;
            adv_q          <= 1'b0;
            tx.o_tx_start  <= 1'b0;
            tx.o_init_addr <= '0;
            tx.o_pix_bit   <= '0;
            o_row_addr     <= '0;
            o_oe_n         <= 1'b1;
            o_busy         <= 1'b0;
            o_frame_done   <= 1'b0;
        end else begin
            tx.o_tx_start <= 1'b0;
            o_frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_enable && tx.i_tx_ready) begin
                        row_q          <= '0;
                        bit_q          <= '0;
                        oe_base_q      <= i_oe_base;
                        tx.o_tx_start  <= 1'b1;
                        tx.o_init_addr <= '0;
                        tx.o_pix_bit   <= '0;
                        o_busy         <= 1'b1;
                        state          <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!tx.i_tx_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx.i_tx_ready) begin
                        o_row_addr <= row_q;
                        dead_cnt   <= dead_wd'(dead_p - 1);
                        state      <= BLANK;
                    end
                end
                BLANK: begin
                    dead_cnt <= dead_cnt - 1'b1;
                    if (dead_cnt == '0) begin
                        adv_q <= 1'b0;
                        if (on_time != '0) begin
                            o_oe_n <= 1'b0;
                            oe_cnt <= on_time - 1'b1;
                            state  <= DISPLAY;
                        end else begin
                            state  <= NEXT;
                        end
                    end
                end
                DISPLAY: begin
                    oe_cnt <= oe_cnt - 1'b1;
                    if (oe_cnt == '0) begin
                        o_oe_n <= 1'b1;
                        state  <= NEXT;
                    end
                end
                NEXT: begin
                    if (!adv_q) begin
                        row_q <= row_nxt;
                        bit_q <= bit_nxt;
                        adv_q <= 1'b1;
                        if (wrap) begin
                            o_frame_done <= 1'b1;
                            oe_base_q    <= i_oe_base;
                        end
                    end
                    if (!i_enable) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else if (tx.i_tx_ready) begin
                        tx.o_tx_start  <= 1'b1;
                        tx.o_init_addr <= addr_wd'(sel_row) * addr_wd'(hpixel_p);
                        tx.o_pix_bit   <= sel_bit;
                        state          <= WAIT_ACK;
                    end
                end
                default: begin
                    o_oe_n <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Scoreboard bench for hub75_bcm_scheduler on an 8x8, 3-plane, 2-segment panel with a
// transmitter model that stays busy for 20 cycles per transaction.
module tb_hub75_bcm_scheduler;
    localparam int hp   = 8;
    localparam int vp   = 8;
    localparam int bp   = 3;
    localparam int sg   = 2;
    localparam int obw  = 16;
    localparam int dead = 2;
    localparam int aw   = 6;
    localparam int bw   = 2;
    localparam int rw   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic [obw-1:0] oe_base = '0;
    logic [rw-1:0]  row_addr;
    logic           oe_n;
    logic           busy;
    logic           fdone;

    hub75_bcm_scheduler_if #(.addr_wd_p(aw), .bit_wd_p(bw)) tx_if ();

    hub75_bcm_scheduler #(
        .hpixel_p(hp), .vpixel_p(vp), .bpp_p(bp), .segments_p(sg),
        .oe_base_wd_p(obw), .dead_p(dead)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_enable(en),
        .i_oe_base(oe_base),
        .tx(tx_if),
        .o_row_addr(row_addr),
        .o_oe_n(oe_n),
        .o_busy(busy),
        .o_frame_done(fdone)
    );

    always #5 clk = ~clk;

    // Transmitter model: goes busy the cycle after a start, ready again 20 cycles later.
    int tx_busy_cnt;
    always @(posedge clk) begin
        if (rst) begin
            tx_if.i_tx_ready <= 1'b1;
            tx_busy_cnt      <= 0;
        end else if (tx_if.o_tx_start) begin
            tx_if.i_tx_ready <= 1'b0;
            tx_busy_cnt      <= 20;
        end else if (tx_busy_cnt != 0) begin
            tx_busy_cnt <= tx_busy_cnt - 1;
            if (tx_busy_cnt == 1) tx_if.i_tx_ready <= 1'b1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int addr;
        int pbit;
    } tx_t;

    tx_t exp_tx[$];
    int  exp_win[$];
    int  exp_win_row[$];
    int  exp_fd_win[$];

    // Expected transactions/windows for the first `count` planes of a frame at a given LSB time.
    task automatic push_planes(input int base, input int count);
        int nwin;
        nwin = 0;
        for (int i = 0; i < count; i++) begin
            int r;
            int b;
            int on;
            r = i / bp;
            b = i % bp;
            exp_tx.push_back('{r * hp, b});
            on = base * (1 << b);
            if (on != 0) begin
                exp_win.push_back(on);
                exp_win_row.push_back(r);
                nwin++;
            end
        end
        if (count == (vp / sg) * bp) exp_fd_win.push_back(nwin);
    endtask

    int          cyc = 0;
    int          rise_cyc = -100;
    logic        prev_ready = 1'b1;
    logic        prev_start = 1'b0;
    logic        prev_oe_n = 1'b1;
    logic [rw-1:0] prev_row = '0;
    int          win_len = 0;
    int          tx_in_frame = 0;
    int          win_in_frame = 0;
    int          frames = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_ready   = 1'b1;
            prev_start   = 1'b0;
            prev_oe_n    = 1'b1;
            prev_row     = row_addr;
            win_len      = 0;
            tx_in_frame  = 0;
            win_in_frame = 0;
        end else begin
            if (tx_if.i_tx_ready && !prev_ready) rise_cyc = cyc;
            if (fdone) begin
                chk("fd_tx_count", tx_in_frame, (vp / sg) * bp);
                if (exp_fd_win.size() == 0) chk("fd_extra", 1, 0);
                else chk("fd_win_count", win_in_frame, exp_fd_win.pop_front());
                frames++;
                tx_in_frame  = 0;
                win_in_frame = 0;
            end
            if (tx_if.o_tx_start) begin
                chk("tx_width", prev_start, 0);
                if (exp_tx.size() == 0) begin
                    chk("tx_extra", 1, 0);
                end else begin
                    tx_t t;
                    t = exp_tx.pop_front();
                    chk("tx_addr", tx_if.o_init_addr, t.addr);
                    chk("tx_bit", tx_if.o_pix_bit, t.pbit);
                end
                tx_in_frame++;
            end
            if (row_addr != prev_row) chk("row_chg_oe", {prev_oe_n, oe_n}, 3);
            if (!oe_n) begin
                if (prev_oe_n) chk("blank_gap", cyc - rise_cyc, 3);
                win_len++;
            end else if (!prev_oe_n) begin
                if (exp_win.size() == 0) begin
                    chk("win_extra", 1, 0);
                end else begin
                    chk("win_len", win_len, exp_win.pop_front());
                    chk("win_row", row_addr, exp_win_row.pop_front());
                end
                win_len = 0;
                win_in_frame++;
            end
            prev_ready = tx_if.i_tx_ready;
            prev_start = tx_if.o_tx_start;
            prev_oe_n  = oe_n;
            prev_row   = row_addr;
        end
    end

    task automatic wait_frames(input int n, input string tag);
        int k;
        k = 0;
        while (frames < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, frames, n);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        en = 1'b0;
        oe_base = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", tx_if.o_tx_start, 0);
        chk("rst_init_addr", tx_if.o_init_addr, 0);
        chk("rst_pix_bit", tx_if.o_pix_bit, 0);
        chk("rst_row_addr", row_addr, 0);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", fdone, 0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1 at LSB=4; LSB changes to 1 mid-frame and only frame 2 picks it up.
        push_planes(4, 12);
        oe_base = 16'd4;
        en = 1'b1;
        k = 0;
        while (tx_in_frame < 5 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("mid_frame_reached", tx_in_frame >= 5, 1);
        oe_base = 16'd1;
        push_planes(1, 12);
        wait_frames(1, "frame1_done");

        // Frame 3 runs with no on-time at all.
        oe_base = 16'd0;
        push_planes(0, 12);
        wait_frames(2, "frame2_done");

        // Frame 4 at LSB=4, stopped during the display window of row 2, bit 1.
        oe_base = 16'd4;
        push_planes(4, 8);
        wait_frames(3, "frame3_done");
        k = 0;
        while (tx_in_frame < 8 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("row2_bit1_started", tx_in_frame, 8);
        k = 0;
        while (oe_n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("row2_bit1_display", oe_n, 0);
        en = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("stop_busy", busy, 0);
        repeat (20) @(negedge clk);
        chk("stop_oe_n", oe_n, 1);
        chk("stop_tx_left", exp_tx.size(), 0);
        chk("stop_win_left", exp_win.size(), 0);
        chk("stop_frames", frames, 3);

        // Re-enable restarts at row 0, bit 0; reset hits while the transmitter is busy.
        push_planes(4, 1);
        en = 1'b1;
        k = 0;
        while (exp_tx.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("restart_tx_seen", exp_tx.size(), 0);
        k = 0;
        while (tx_if.i_tx_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("restart_tx_busy", tx_if.i_tx_ready, 0);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        en = 1'b0;
        @(negedge clk);
        chk("midrst_oe_n", oe_n, 1);
        chk("midrst_tx_start", tx_if.o_tx_start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_done", fdone, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_fd", frames, 3);
        chk("midrst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
